// File: rtl/tube_pkg.sv
// Shared definitions for the 7-segment tube driver: register map, CTRL field
// positions and the hex-to-segment table (active-low {dp,g,f,e,d,c,b,a}).
package tube_pkg;

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_CTRL  = 2'd1,
        REG_RSVD2 = 2'd2,
        REG_RSVD3 = 2'd3
    } reg_addr_e;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLANK_BIT = 1;
    localparam int CTRL_DIG_LSB   = 4;
    localparam int CTRL_DP_LSB    = 8;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
    // Only EN, BLANK, the tube2 digit and the DP mask are stored; other bits read 0.
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FFF3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_lookup(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment decoder; dp_i lights the
// decimal point by clearing bit 7.
import tube_pkg::*;

module hex_to_seg (
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] raw_s;

    // Table lookup, then overlay the decimal point.
    always_comb begin
        raw_s = seg_lookup(nibble_i);
        seg_o = {raw_s[7] & ~dp_i, raw_s[6:0]};
    end

endmodule

// File: rtl/digital_tube_driver.sv
// Bus-mapped driver for three 7-segment tube groups: DATA/CTRL registers,
// digit-scan prescaler and registered segment/select outputs.
import tube_pkg::*;

module digital_tube_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);

    localparam int             CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [31:0]      data_q, data_d;
    logic [31:0]      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       sel_q, sel_d;
    logic             sel2_q, sel2_d;
    logic [7:0]       tube0_q, tube0_d;
    logic [7:0]       tube1_q, tube1_d;
    logic [7:0]       tube2_q, tube2_d;

    logic       en_s, blank_en_s;
    logic [7:0] zero_from_s;
    logic [3:0] nib_lo_s, nib_hi_s;
    logic       dp_lo_s, dp_hi_s;
    logic       blank_lo_s, blank_hi_s;
    logic [7:0] seg_lo_s, seg_hi_s, seg_t2_s;

    assign en_s       = ctrl_q[CTRL_EN_BIT];
    assign blank_en_s = ctrl_q[CTRL_BLANK_BIT];

    // Read mux; reserved words read as zero.
    always_comb begin
        rdata = 32'h0000_0000;
        case (reg_addr_e'(addr))
            REG_DATA: rdata = data_q;
            REG_CTRL: rdata = ctrl_q;
            default:  rdata = 32'h0000_0000;
        endcase
    end

    // Register write decode.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (we) begin
            case (reg_addr_e'(addr))
                REG_DATA: data_d = wdata;
                REG_CTRL: ctrl_d = wdata & CTRL_WMASK;
                default: begin
                    data_d = data_q;
                    ctrl_d = ctrl_q;
                end
            endcase
        end else begin
            data_d = data_q;
            ctrl_d = ctrl_q;
        end
    end

    // Prescaler and scan index; both parked at zero while disabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_s) begin
            cnt_d = CNT_ZERO;
            idx_d = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            idx_d = idx_q;
        end
    end

    // zero_from_s[i]: DATA nibbles i..7 are all zero (leading-zero blanking).
    always_comb begin
        zero_from_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            zero_from_s[i] = ((data_q >> (i * 4)) == 32'h0000_0000);
        end
    end

    // Select current digit of each group; DP mask bit index is 8+digit.
    always_comb begin
        nib_lo_s   = data_q[{1'b0, idx_q, 2'b00} +: 4];
        nib_hi_s   = data_q[{1'b1, idx_q, 2'b00} +: 4];
        dp_lo_s    = ctrl_q[{3'b010, idx_q}];
        dp_hi_s    = ctrl_q[{3'b011, idx_q}];
        blank_lo_s = blank_en_s && (idx_q != 2'd0) && zero_from_s[{1'b0, idx_q}];
        blank_hi_s = blank_en_s && zero_from_s[{1'b1, idx_q}];
    end

    hex_to_seg u_seg_lo (.nibble_i(nib_lo_s), .dp_i(dp_lo_s), .seg_o(seg_lo_s));
    hex_to_seg u_seg_hi (.nibble_i(nib_hi_s), .dp_i(dp_hi_s), .seg_o(seg_hi_s));
    hex_to_seg u_seg_t2 (
        .nibble_i(ctrl_q[CTRL_DIG_LSB +: 4]),
        .dp_i    (1'b0),
        .seg_o   (seg_t2_s)
    );

    // Output next-state; a blanked digit still shows its decimal point.
    always_comb begin
        sel_d   = 4'b0000;
        sel2_d  = 1'b0;
        tube0_d = SEG_BLANK;
        tube1_d = SEG_BLANK;
        tube2_d = SEG_BLANK;
        if (en_s) begin
            sel_d   = 4'b0001 << idx_q;
            sel2_d  = 1'b1;
            tube0_d = blank_lo_s ? {~dp_lo_s, 7'h7F} : seg_lo_s;
            tube1_d = blank_hi_s ? {~dp_hi_s, 7'h7F} : seg_hi_s;
            tube2_d = seg_t2_s;
        end else begin
            sel_d   = 4'b0000;
            sel2_d  = 1'b0;
            tube0_d = SEG_BLANK;
            tube1_d = SEG_BLANK;
            tube2_d = SEG_BLANK;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            data_q  <= 32'h0000_0000;
            ctrl_q  <= CTRL_RESET;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 2'd0;
            sel_q   <= 4'b0000;
            sel2_q  <= 1'b0;
            tube0_q <= SEG_BLANK;
            tube1_q <= SEG_BLANK;
            tube2_q <= SEG_BLANK;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            sel2_q  <= sel2_d;
            tube0_q <= tube0_d;
            tube1_q <= tube1_d;
            tube2_q <= tube2_d;
        end
    end

    assign digital_tube0     = tube0_q;
    assign digital_tube1     = tube1_q;
    assign digital_tube2     = tube2_q;
    assign digital_tube_sel0 = sel_q;
    assign digital_tube_sel1 = sel_q;
    assign digital_tube_sel2 = sel2_q;

endmodule

// File: tb/tb_digital_tube_driver.sv
// Directed self-checking bench for digital_tube_driver with a 4-cycle digit dwell.
module tb_digital_tube_driver;

    localparam int SD = 4;

    logic        clk_in;
    logic        sys_rstn;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
    logic [3:0]  digital_tube_sel0, digital_tube_sel1;
    logic        digital_tube_sel2;

    logic clk_run;
    int   n_tests;
    int   n_fail;
    int   edge_n;
    int   base_n;

    digital_tube_driver #(.SCAN_DIV(SD)) dut (
        .clk_in           (clk_in),
        .sys_rstn         (sys_rstn),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .rdata            (rdata),
        .digital_tube0    (digital_tube0),
        .digital_tube_sel0(digital_tube_sel0),
        .digital_tube1    (digital_tube1),
        .digital_tube_sel1(digital_tube_sel1),
        .digital_tube2    (digital_tube2),
        .digital_tube_sel2(digital_tube_sel2)
    );

    initial begin
        clk_in = 1'b0;
        wait (clk_run);
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        edge_n++;
    endtask

    // Digit index expected on the pins, counted from the first enabled output edge.
    function automatic int exp_idx();
        return ((edge_n - base_n) / SD) % 4;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic check_off(input string tag);
        check({tag, "_t0"},   32'(digital_tube0), 32'h0000_00FF);
        check({tag, "_t1"},   32'(digital_tube1), 32'h0000_00FF);
        check({tag, "_t2"},   32'(digital_tube2), 32'h0000_00FF);
        check({tag, "_sel0"}, 32'(digital_tube_sel0), 32'h0);
        check({tag, "_sel1"}, 32'(digital_tube_sel1), 32'h0);
        check({tag, "_sel2"}, 32'(digital_tube_sel2), 32'h0);
    endtask

    // t0v/t1v pack the expected segment bytes {digit3,digit2,digit1,digit0}.
    task automatic scan_check(input string tag, input int n, input logic [31:0] t0v,
                              input logic [31:0] t1v, input logic [7:0] t2);
        int k;
        for (int i = 0; i < n; i++) begin
            tick();
            k = exp_idx();
            check({tag, "_sel0"}, 32'(digital_tube_sel0), 32'(4'b0001 << k));
            check({tag, "_sel1"}, 32'(digital_tube_sel1), 32'(4'b0001 << k));
            check({tag, "_t0"},   32'(digital_tube0), 32'(t0v[k*8 +: 8]));
            check({tag, "_t1"},   32'(digital_tube1), 32'(t1v[k*8 +: 8]));
            check({tag, "_t2"},   32'(digital_tube2), 32'(t2));
            check({tag, "_sel2"}, 32'(digital_tube_sel2), 32'h1);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        edge_n   = 0;
        base_n   = 1;
        clk_run  = 1'b0;
        sys_rstn = 1'b1;
        we       = 1'b0;
        addr     = 2'd0;
        wdata    = 32'h0;

        // Asynchronous reset with the clock stopped.
        #1 sys_rstn = 1'b0;
        #1 check_off("rst_noclk");
        clk_run = 1'b1;
        tick();
        tick();
        check_off("rst_held");

        sys_rstn = 1'b1;
        edge_n   = 0;
        base_n   = 1;
        addr = 2'd0; #1 check("rd_data_rst", rdata, 32'h0);
        addr = 2'd1; #1 check("rd_ctrl_rst", rdata, 32'h1);
        scan_check("first", 1, 32'hC0C0C0C0, 32'hC0C0C0C0, 8'hC0);

        // DATA write: pre-write read value, then one-cycle latency to the pins.
        addr  = 2'd0;
        wdata = 32'h1234_5678;
        we    = 1'b1;
        #1 check("rdata_prewrite", rdata, 32'h0);
        tick();
        we = 1'b0;
        check("latency_old_t0", 32'(digital_tube0), 32'h0000_00C0);
        check("rd_data_new", rdata, 32'h1234_5678);
        scan_check("scan", 15, 32'h9282F880, 32'hF9A4B099, 8'hC0);

        // Leading-zero blanking.
        wr(2'd0, 32'h0000_00A0);
        wr(2'd1, 32'h0000_0003);
        scan_check("blank", 16, 32'hFFFF88C0, 32'hFFFFFFFF, 8'hC0);

        // Decimal point on digit 0 and tube2 digit F.
        wr(2'd1, 32'h0000_01F1);
        scan_check("dp", 16, 32'hC0C08840, 32'hC0C0C0C0, 8'h8E);

        // Disable while digit 2 is showing, then re-enable.
        for (int i = 0; i < 16; i++) begin
            if (exp_idx() == 2) break;
            tick();
        end
        check("at_idx2_sel0", 32'(digital_tube_sel0), 32'h4);
        wr(2'd1, 32'h0000_0000);
        tick();
        check_off("dis1");
        tick();
        check_off("dis2");
        wr(2'd1, 32'h0000_0001);
        check_off("dis_wr_edge");
        base_n = edge_n + 1;
        scan_check("reen", 9, 32'hC0C088C0, 32'hC0C0C0C0, 8'hC0);

        // Reserved addresses.
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        addr = 2'd0; #1 check("rsvd_data", rdata, 32'h0000_00A0);
        addr = 2'd1; #1 check("rsvd_ctrl", rdata, 32'h0000_0001);
        addr = 2'd2; #1 check("rsvd_rd2",  rdata, 32'h0);
        addr = 2'd3; #1 check("rsvd_rd3",  rdata, 32'h0);

        // Reset mid-scan.
        tick();
        tick();
        sys_rstn = 1'b0;
        #1 check_off("rst_mid");
        tick();
        check_off("rst_mid_held");
        sys_rstn = 1'b1;
        edge_n   = 0;
        base_n   = 1;
        addr = 2'd0; #1 check("rd_data_rst2", rdata, 32'h0);
        addr = 2'd1; #1 check("rd_ctrl_rst2", rdata, 32'h1);
        scan_check("resume", 5, 32'hC0C0C0C0, 32'hC0C0C0C0, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
